// File: rtl/switch_debouncer.sv
// Switch conditioner: 2-FF synchroniser, counter debounce FSM, level and edge pulses.
// Define SW_EDGE_COUNT_EN to build the 8-bit accepted-rising-edge counter.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_raw,
  output logic       sw_level,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic [7:0] edge_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LO,
    WAIT_HI,
    STABLE_HI,
    WAIT_LO
  } state_t;

  logic             r_sync0;
  logic             r_sync1;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  state_t           w_next_state;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_rise;
  logic             w_fall;

  // r_cnt holds how many differing sync1 cycles have been seen so far;
  // the D-th such cycle is accepted on the same edge that samples it.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = '0;
    w_rise       = 1'b0;
    w_fall       = 1'b0;
    unique case (r_state)
      STABLE_LO: begin
        if (r_sync1) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_next_state = STABLE_HI;
            w_rise       = 1'b1;
          end else begin
            w_next_state = WAIT_HI;
            w_next_cnt   = ONE;
          end
        end
      end
      WAIT_HI: begin
        if (!r_sync1) begin
          w_next_state = STABLE_LO;
        end else if (r_cnt == LAST) begin
          w_next_state = STABLE_HI;
          w_rise       = 1'b1;
        end else begin
          w_next_cnt = r_cnt + ONE;
        end
      end
      STABLE_HI: begin
        if (!r_sync1) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_next_state = STABLE_LO;
            w_fall       = 1'b1;
          end else begin
            w_next_state = WAIT_LO;
            w_next_cnt   = ONE;
          end
        end
      end
      WAIT_LO: begin
        if (r_sync1) begin
          w_next_state = STABLE_HI;
        end else if (r_cnt == LAST) begin
          w_next_state = STABLE_LO;
          w_fall       = 1'b1;
        end else begin
          w_next_cnt = r_cnt + ONE;
        end
      end
      default: w_next_state = STABLE_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync0 <= 1'b0;
      r_sync1 <= 1'b0;
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync0 <= sw_raw;
      r_sync1 <= r_sync0;
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_rise  <= w_rise;
      r_fall  <= w_fall;
      if (w_rise)
        r_level <= 1'b1;
      else if (w_fall)
        r_level <= 1'b0;
    end
  end

  assign sw_level   = r_level;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

`ifdef SW_EDGE_COUNT_EN
  logic [7:0] r_edge_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_edge_cnt <= 8'd0;
    else if (w_rise)
      r_edge_cnt <= r_edge_cnt + 8'd1;
  end

  assign edge_count = r_edge_cnt;
`else
  assign edge_count = 8'd0;
`endif

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer with DEBOUNCE_CYCLES=4.
// A behavioural run-length model feeds an expected-output queue.
module tb_switch_debouncer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw_raw = 1'b0;
  logic       sw_level;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] edge_count;

  switch_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sw_level   (sw_level),
    .rise_pulse (rise_pulse),
    .fall_pulse (fall_pulse),
    .edge_count (edge_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [10:0] exp_q[$];
  logic [10:0] e;
  logic [10:0] obs;

  logic       m_s0 = 0, m_s1 = 0, m_lvl = 0;
  logic       m_rise = 0, m_fall = 0;
  logic [7:0] m_cnt = 0;
  int         m_run = 0;

  // Advance the model by one edge, push its prediction, then clock the DUT.
  task automatic drive(input logic raw, input logic r);
    sw_raw = raw;
    rst    = r;
    if (r) begin
      m_s0 = 0; m_s1 = 0; m_lvl = 0; m_run = 0;
      m_rise = 0; m_fall = 0; m_cnt = 0;
    end else begin
      m_rise = 0;
      m_fall = 0;
      if (m_s1 != m_lvl) begin
        m_run++;
        if (m_run == D) begin
          m_lvl = ~m_lvl;
          m_run = 0;
          if (m_lvl) begin
            m_rise = 1;
`ifdef SW_EDGE_COUNT_EN
            m_cnt = m_cnt + 8'd1;
`endif
          end else begin
            m_fall = 1;
          end
        end
      end else begin
        m_run = 0;
      end
      m_s1 = m_s0;
      m_s0 = raw;
    end
    exp_q.push_back({m_lvl, m_rise, m_fall, m_cnt});
    @(posedge clk);
    #1;
    obs = {sw_level, rise_pulse, fall_pulse, edge_count};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e || obs !== 11'd0) begin
        n_fail++;
        $display("FAIL reset_hold: got %h want %h", obs, e);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_release[%0d]: got %h want %h", i, obs, e);
      end
      if (i == 6) begin
        n_tests++;
        if ({sw_level, rise_pulse} !== 2'b11) begin
          n_fail++;
          $display("FAIL reset_rise_e6: got %b want 11", {sw_level, rise_pulse});
        end
      end
    end
  endtask

  task automatic test_press();
    logic [7:0] want;
    drive(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL press[%0d]: got %h want %h", i, obs, e);
      end
      if (i == 5 || i == 6 || i == 7) begin
        n_tests++;
        if (rise_pulse !== (i == 6)) begin
          n_fail++;
          $display("FAIL press_pulse_e%0d: got %b want %b", i, rise_pulse, i == 6);
        end
      end
    end
`ifdef SW_EDGE_COUNT_EN
    want = 8'd1;
`else
    want = 8'd0;
`endif
    n_tests++;
    if (edge_count !== want) begin
      n_fail++;
      $display("FAIL press_count: got %0d want %0d", edge_count, want);
    end
  endtask

  task automatic test_release();
    int rises = 0;
    drive(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0);
      void'(exp_q.pop_front());
    end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL release[%0d]: got %h want %h", i, obs, e);
      end
      if (rise_pulse) rises++;
      if (i == 6) begin
        n_tests++;
        if ({sw_level, fall_pulse} !== 2'b01) begin
          n_fail++;
          $display("FAIL release_e6: got %b want 01", {sw_level, fall_pulse});
        end
      end
    end
    n_tests++;
    if (rises != 0) begin
      n_fail++;
      $display("FAIL release_no_rise: got %0d want 0", rises);
    end
  endtask

  task automatic test_bounce();
    logic [7:0] pat;
    int rises = 0;
    int at = 0;
    pat = 8'b00110011;
    drive(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 8; i++) begin
      drive(pat[i], 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL bounce_tog[%0d]: got %h want %h", i, obs, e);
      end
      if (rise_pulse) rises++;
    end
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 1'b0);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL bounce_settle[%0d]: got %h want %h", i, obs, e);
      end
      if (rise_pulse) begin
        rises++;
        at = i;
      end
    end
    n_tests++;
    if (rises != 1 || at != 6) begin
      n_fail++;
      $display("FAIL bounce_single: got %0d@%0d want 1@6", rises, at);
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 1; i <= 14; i++) begin
      drive(1'b1, i == 4);
      e = exp_q.pop_front();
      n_tests++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL midrst[%0d]: got %h want %h", i, obs, e);
      end
      if (i == 6 || i == 10) begin
        n_tests++;
        if (rise_pulse !== (i == 10)) begin
          n_fail++;
          $display("FAIL midrst_pulse_e%0d: got %b want %b", i, rise_pulse, i == 10);
        end
      end
    end
  endtask

`ifdef SW_EDGE_COUNT_EN
  task automatic test_wrap();
    int lvl_bad = 0;
    drive(1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int p = 0; p < 256; p++) begin
      for (int i = 0; i < 14; i++) begin
        drive(i < 7, 1'b0);
        e = exp_q.pop_front();
        n_tests++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL wrap[%0d.%0d]: got %h want %h", p, i, obs, e);
        end
        if (i == 6 && sw_level !== 1'b1) lvl_bad++;
      end
      if (p == 254 || p == 255) begin
        n_tests++;
        if (edge_count !== ((p == 254) ? 8'd255 : 8'd0)) begin
          n_fail++;
          $display("FAIL wrap_count_p%0d: got %0d", p, edge_count);
        end
      end
    end
    n_tests++;
    if (lvl_bad != 0) begin
      n_fail++;
      $display("FAIL wrap_level: got %0d misses want 0", lvl_bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_release();
    test_press();
    test_bounce();
    test_mid_reset();
`ifdef SW_EDGE_COUNT_EN
    test_wrap();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
